// File: rtl/video_meas_pkg.sv
// Shared types and constants for the video stream measurement block.
package video_meas_pkg;
    localparam int CNT_WIDTH_DEF   = 16;
    localparam int PIXEL_WIDTH_DEF = 8;

    // Sticky error vector layout
    localparam int ERR_BITS   = 5;
    localparam int ERR_W_LINE = 0;  // line width differs from first line of frame
    localparam int ERR_W_EXP  = 1;  // line width differs from expected width
    localparam int ERR_H      = 2;  // height differs from previous frame / expected
    localparam int ERR_ORDER  = 3;  // de seen while no frame is open
    localparam int ERR_SAT    = 4;  // a geometry/period counter hit all-ones

    typedef enum logic {
        IDLE  = 1'b0,
        FRAME = 1'b1
    } state_t;
endpackage

// File: rtl/video_stream_meas_if.sv
// Pixel stream as emitted by the scaler blocks: data, valid, line/frame strobes
// and an out-of-band frame flush.
interface video_stream_meas_if #(
    parameter int PIXEL_WIDTH = 8
);
    logic [PIXEL_WIDTH-1:0] di_i;
    logic                   de_i;
    logic                   hs_i;
    logic                   vs_i;
    logic                   flush_i;

    modport master (output di_i, de_i, hs_i, vs_i, flush_i);
    modport slave  (input  di_i, de_i, hs_i, vs_i, flush_i);
endinterface

// File: rtl/video_meas_line.sv
// Per-line measurement: pixel counter, line period counter, reference width of
// the frame and the width compares done when a line closes.
module video_meas_line
    import video_meas_pkg::*;
#(
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 active,     // a frame is open
    input  logic                 de,
    input  logic                 start,      // frame opens from idle
    input  logic                 strobe,     // line start inside an open frame
    input  logic                 close,      // current line closes this cycle
    input  logic                 incl,       // close without new line: this cycle's pixel is part of it
    input  logic                 last,       // this close also ends the frame
    input  logic [CNT_WIDTH-1:0] exp_width,
    output logic                 close_nz,   // a non-empty line closes this cycle
    output logic [CNT_WIDTH-1:0] frame_w,    // frame width including the closing line
    output logic [CNT_WIDTH-1:0] line_period,
    output logic                 w_line_err,
    output logic                 w_exp_err,
    output logic                 sat_err
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] pix_cnt, per_cnt, ref_w, closed_w;
    logic                 ref_vld, pix_sat, per_sat;

    // Close-time width and compares; saturation detects a blocked increment
    always_comb begin
        pix_sat    = active && de && !strobe && (pix_cnt == CNT_MAX);
        per_sat    = active && !strobe && (per_cnt == CNT_MAX);
        closed_w   = (incl && de && !pix_sat) ? pix_cnt + ONE : pix_cnt;
        close_nz   = close && (closed_w != '0);
        w_line_err = close_nz && ref_vld && (closed_w != ref_w);
        w_exp_err  = close_nz && (exp_width != '0) && (closed_w != exp_width);
        frame_w    = ref_vld ? ref_w : (close_nz ? closed_w : '0);
        sat_err    = pix_sat || per_sat;
    end

    // Pixel counter: a pixel coincident with a line start belongs to the new line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        pix_cnt <= '0;
        else if (start || strobe)          pix_cnt <= {{(CNT_WIDTH-1){1'b0}}, de};
        else if (incl)                     pix_cnt <= '0;
        else if (active && de && !pix_sat) pix_cnt <= pix_cnt + ONE;
    end

    // Line period: restart at 1 on each strobe, latch the reached value at the next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_cnt     <= '0;
            line_period <= '0;
        end else begin
            if (strobe) line_period <= per_cnt;
            if (start || strobe)        per_cnt <= ONE;
            else if (active && !per_sat) per_cnt <= per_cnt + ONE;
        end
    end

    // Reference width: first non-empty line of each frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_vld <= 1'b0;
            ref_w   <= '0;
        end else if (close && last) begin
            ref_vld <= 1'b0;
        end else if (close_nz && !ref_vld) begin
            ref_vld <= 1'b1;
            ref_w   <= closed_w;
        end
    end
endmodule

// File: rtl/video_stream_meas.sv
// Receiver-side monitor for the scaler pixel stream: frame geometry, line
// period, frame count, per-frame checksum and sticky protocol errors.
module video_stream_meas
    import video_meas_pkg::*;
#(
    parameter int PIXEL_WIDTH = PIXEL_WIDTH_DEF,
    parameter int CNT_WIDTH   = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    video_stream_meas_if.slave   vid,
    input  logic [CNT_WIDTH-1:0] exp_width,
    input  logic [CNT_WIDTH-1:0] exp_height,
    input  logic                 clr_err,
    output logic [CNT_WIDTH-1:0] meas_width,
    output logic [CNT_WIDTH-1:0] meas_height,
    output logic [CNT_WIDTH-1:0] meas_line_period,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [31:0]          chksum,
    output logic                 frame_done,
    output logic [ERR_BITS-1:0]  err
);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);

    state_t                state;
    logic [PIXEL_WIDTH-1:0] di;
    logic [31:0]           pix_add, sum, sum_close;
    logic [CNT_WIDTH-1:0]  line_cnt, h_close, frame_w;
    logic                  in_frame, start, strobe, fclose, close, incl;
    logic                  close_nz, line_sat, h_err, have_prev;
    logic                  w_line_err, w_exp_err, sat_err;
    logic [ERR_BITS-1:0]   new_err;

    assign di = vid.di_i;

    // Strobe decode; vs wins over flush, frame close always closes the line first
    always_comb begin
        in_frame  = (state == FRAME);
        start     = !in_frame && vid.vs_i;
        strobe    = in_frame && (vid.hs_i || vid.vs_i);
        fclose    = in_frame && (vid.vs_i || vid.flush_i);
        close     = strobe || fclose;
        incl      = fclose && !strobe;
        pix_add   = vid.de_i ? {{(32-PIXEL_WIDTH){1'b0}}, di} : 32'd0;
        line_sat  = close_nz && (line_cnt == CNT_MAX);
        h_close   = (close_nz && !line_sat) ? line_cnt + ONE : line_cnt;
        sum_close = incl ? sum + pix_add : sum;
        h_err     = fclose && ((have_prev && (h_close != meas_height)) ||
                               ((exp_height != '0) && (h_close != exp_height)));
        new_err             = '0;
        new_err[ERR_W_LINE] = w_line_err;
        new_err[ERR_W_EXP]  = w_exp_err;
        new_err[ERR_H]      = h_err;
        new_err[ERR_ORDER]  = !in_frame && vid.de_i && !vid.vs_i;
        new_err[ERR_SAT]    = sat_err || line_sat;
    end

    video_meas_line #(.CNT_WIDTH(CNT_WIDTH)) u_line (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (in_frame),
        .de          (vid.de_i),
        .start       (start),
        .strobe      (strobe),
        .close       (close),
        .incl        (incl),
        .last        (fclose),
        .exp_width   (exp_width),
        .close_nz    (close_nz),
        .frame_w     (frame_w),
        .line_period (meas_line_period),
        .w_line_err  (w_line_err),
        .w_exp_err   (w_exp_err),
        .sat_err     (sat_err)
    );

    // Frame FSM with line count and running checksum; vs reopens in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            line_cnt <= '0;
            sum      <= '0;
        end else begin
            case (state)
                IDLE: if (vid.vs_i) begin
                    state    <= FRAME;
                    line_cnt <= '0;
                    sum      <= pix_add;
                end
                FRAME: if (fclose) begin
                    line_cnt <= '0;
                    sum      <= vid.vs_i ? pix_add : 32'd0;
                    if (!vid.vs_i) state <= IDLE;
                end else begin
                    if (close_nz && !line_sat) line_cnt <= line_cnt + ONE;
                    sum <= sum + pix_add;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Publish registers, updated on the edge that samples the frame close
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meas_width  <= '0;
            meas_height <= '0;
            frame_cnt   <= '0;
            chksum      <= '0;
            frame_done  <= 1'b0;
            have_prev   <= 1'b0;
        end else begin
            frame_done <= fclose;
            if (fclose) begin
                meas_width  <= frame_w;
                meas_height <= h_close;
                chksum      <= sum_close;
                frame_cnt   <= frame_cnt + ONE;
                have_prev   <= 1'b1;
            end
        end
    end

    // Sticky errors; a new error in the clear cycle survives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= '0;
        else        err <= (clr_err ? '0 : err) | new_err;
    end
endmodule
